// File: rtl/block_transposer.sv
// Ping-pong N x N block buffer: writes arrive row-major, each full bank is read back
// column-major (transpose) or row-major (pass-through) through a registered output stage.
module block_transposer #(
    parameter int DATA_W = 12,
    parameter int N      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_first,
    output logic              out_last,
    output logic [1:0]        pending
);
    // state  | meaning
    // IDLE   | no full bank is being read; waiting for full[rbank]
    // STREAM | reading bank rbank, may roll straight into the other bank
    typedef enum logic {IDLE, STREAM} state_t;

    localparam int LG    = $clog2(N);
    localparam int AW    = 2 * LG + 1;
    localparam int DEPTH = 2 * N * N;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t          state, state_nxt;
    logic            wbank, rbank;
    logic [LG-1:0]   wr, wc, ra, rb;
    logic [1:0]      full, mode;

    logic            wr_fire, wr_end, wr_start;
    logic            rd_fire, rd_end;
    logic            drained, fbank, have, load;
    logic [AW-1:0]   ld_addr;
    logic            ld_first, ld_last;

    assign in_ready = !full[wbank];
    assign wr_fire  = in_valid && in_ready;
    assign wr_start = wr_fire && (wr == '0) && (wc == '0);
    assign wr_end   = wr_fire && (wr == '1) && (wc == '1);

    assign rd_fire  = out_valid && out_ready;
    assign rd_end   = rd_fire && out_last;

    // Once the last sample of rbank sits in the output register, fetching moves
    // on to the other bank so the next block follows without a bubble.
    assign drained  = out_valid && out_last;
    assign fbank    = drained ? ~rbank : rbank;
    assign load     = have && (!out_valid || out_ready);
    assign ld_addr  = mode[fbank] ? {fbank, ra, rb} : {fbank, rb, ra};
    assign ld_first = (ra == '0) && (rb == '0);
    assign ld_last  = (ra == '1) && (rb == '1);

    assign pending  = {1'b0, full[0]} + {1'b0, full[1]};

    always_comb begin
        state_nxt = state;
        have      = 1'b0;
        case (state)
            IDLE: begin
                have = full[rbank];
                if (full[rbank])
                    state_nxt = STREAM;
            end
            STREAM: begin
                have = drained ? full[~rbank] : 1'b1;
                if (rd_end && !full[~rbank])
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_fire)
            mem[{wbank, wr, wc}] <= in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbank <= 1'b0;
            wr    <= '0;
            wc    <= '0;
            mode  <= '0;
        end else if (wr_fire) begin
            if (wr_start)
                mode[wbank] <= in_mode;
            if (wc == '1) begin
                wc <= '0;
                wr <= wr + 1'b1;
            end else begin
                wc <= wc + 1'b1;
            end
            if (wr_end)
                wbank <= ~wbank;
        end
    end

    // A finishing write and a finishing read always touch different banks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full  <= '0;
            rbank <= 1'b0;
        end else begin
            if (wr_end)
                full[wbank] <= 1'b1;
            if (rd_end) begin
                full[rbank] <= 1'b0;
                rbank       <= ~rbank;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ra        <= '0;
            rb        <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= mem[ld_addr];
                out_first <= ld_first;
                out_last  <= ld_last;
                if (rb == '1) begin
                    rb <= '0;
                    ra <= ra + 1'b1;
                end else begin
                    rb <= rb + 1'b1;
                end
            end else if (rd_fire) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/block_transposer.md
BLOCK_TRANSPOSER -- requirements
Module: block_transposer

Interface
REQ-001 Parameter DATA_W, default 12, sample width in bits, range 1..32.
REQ-002 Parameter N, default 8, block edge length, power of two, range 2..32; one block is N*N samples.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset, deassertion synchronous to clk.
REQ-005 in_valid  input  1  in_data/in_mode valid this cycle.
REQ-006 in_ready  output  1  block can accept a sample this cycle.
REQ-007 in_data  input  DATA_W  sample, arrives in row-major order within a block.
REQ-008 in_mode  input  1  0 = transpose (column-major readout), 1 = pass-through (row-major readout); meaningful only on the first sample of a block.
REQ-009 out_valid  output  1  out_data/out_first/out_last valid.
REQ-010 out_ready  input  1  consumer accepts the sample this cycle.
REQ-011 out_data  output  DATA_W  output sample.
REQ-012 out_first  output  1  high with sample 0 of an output block.
REQ-013 out_last  output  1  high with sample N*N-1 of an output block.
REQ-014 pending  output  2  number of full banks not yet completely read (0..2).

Function
REQ-015 Storage SHALL be two banks (ping-pong) of N*N x DATA_W words, addressed {bank, row, col}.
REQ-016 A write transfer occurs on an edge where in_valid and in_ready are both high; a read transfer on an edge where out_valid and out_ready are both high.
REQ-017 Write side: bank pointer wbank, row counter wr and column counter wc (each log2(N) bits); sample stored at {wbank, wr, wc}; wc increments per transfer, wrapping to 0 and incrementing wr.
REQ-018 in_mode SHALL be latched into mode[wbank] on the transfer with wr=0, wc=0; ignored on all other transfers.
REQ-019 On the transfer with wr=wc=N-1, full[wbank] SHALL set and wbank SHALL toggle, wr and wc returning to 0.
REQ-020 in_ready SHALL equal !full[wbank] (combinational from registers, no dependence on in_valid).
REQ-021 Read side FSM, states IDLE and STREAM; IDLE -> STREAM when full[rbank] is set; STREAM -> IDLE after the read transfer of sample N*N-1 when full[other bank] is clear, else remains in STREAM on the other bank with no bubble.
REQ-022 Read counters ra (major) and rb (minor); address is {rbank, rb, ra} in transpose mode and {rbank, ra, rb} in pass-through, using mode[rbank].
REQ-023 out_data SHALL be driven from an output register loaded when the FSM has a sample to present and (!out_valid or out_ready); out_valid SHALL be that register's valid flag.
REQ-024 On the read transfer of sample N*N-1, full[rbank] SHALL clear and rbank toggle in the same edge.
REQ-025 Latency: sample 0 of a block SHALL be presented with out_valid high on the first edge after full[] sets for that bank, i.e. one cycle after the final write transfer, when the read side is idle.
REQ-026 Sustained throughput SHALL be one sample per cycle in and out when out_ready is held high.
REQ-027 Simultaneous last-write into one bank and last-read from the other on the same edge SHALL both take effect; pending unchanged.
REQ-028 out_valid low with out_ready high SHALL not advance read counters; out_ready low SHALL hold out_data, out_first, out_last stable.
REQ-029 pending SHALL equal full[0]+full[1].

Reset
REQ-030 On rst_n low: wbank, rbank, wr, wc, ra, rb, full[], mode[] = 0; FSM = IDLE; out_valid, out_first, out_last = 0; out_data = 0; in_ready = 1 after the reset state is established; pending = 0.
REQ-031 Reset mid-block SHALL discard all partial and full bank contents; memory array contents need not be cleared.

Verification
REQ-032 N=8, DATA_W=12, mode 0, inputs 0..63 with out_ready=1 -> out_valid one cycle after last write; outputs 0,8,16..56,1,9..63; out_first with 0, out_last with 63.
REQ-033 Same with mode 1 -> outputs 0,1,2..63 in order.
REQ-034 Three blocks back-to-back, out_ready=0 -> in_ready low after 128 transfers, pending=2; raise out_ready -> block 1 streams, in_ready rises after its last read, block 3 accepted.
REQ-035 Random in_valid/out_ready toggling over 20 blocks with random modes -> output matches scoreboard exactly, no loss or duplication, out_data stable while stalled.
REQ-036 rst_n asserted after 30 writes of a block -> all outputs at reset values; subsequent fresh block 100..163 transposed correctly.
REQ-037 N=4, DATA_W=8 build, mode 0, inputs 0..15 -> outputs 0,4,8,12,1,5..15.
